// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Takes exceptions and MRETs that commit in the writeback stage. It
//   sequences the pipeline flush, the mepc/mcause/mtval CSR write and the
//   fetch redirect.
//
// Ports
//   clk, resetb           clock, asynchronous active-low reset
//   XB_bubble             writeback slot holds a bubble (requests ignored)
//   exc_req[3:0]          exception requests: instr misaligned, illegal
//                         instr, load misaligned, store misaligned
//   exc_pc, exc_tval      PC and trap value of the faulting instruction
//   mret_req              MRET committing in writeback
//   mtvec, mepc_in        trap vector base (direct mode), current mepc
//   busy                  sequencer active; doubles as the pipeline stall
//   flush                 kill younger in-flight instructions
//   csr_we                one-cycle write strobe for mepc/mcause/mtval
//   csr_*_wdata           CSR write data
//   redirect_valid/_pc    fetch redirect strobe and target
//   trap_count            saturating count of exceptions taken
module trap_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             XB_bubble,
  input  logic [3:0]       exc_req,
  input  logic [31:0]      exc_pc,
  input  logic [31:0]      exc_tval,
  input  logic             mret_req,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc_in,
  output logic             busy,
  output logic             flush,
  output logic             csr_we,
  output logic [31:0]      csr_mepc_wdata,
  output logic [31:0]      csr_mcause_wdata,
  output logic [31:0]      csr_mtval_wdata,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SAVE,
    S_VECTOR,
    S_RET
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tval_q, tval_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Lowest set request bit wins; mcause is twice the bit index.
  function automatic logic [2:0] cause_of(input logic [3:0] req);
    logic [2:0] c;
    c = 3'd6;
    if (req[2]) c = 3'd4;
    if (req[1]) c = 3'd2;
    if (req[0]) c = 3'd0;
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!XB_bubble) begin
          // An exception always beats a simultaneous MRET.
          if (|exc_req) begin
            state_d = S_FLUSH;
            pc_d    = exc_pc;
            tval_d  = exc_tval;
            cause_d = cause_of(exc_req);
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (mret_req) begin
            state_d = S_RET;
          end
        end
      end
      S_FLUSH:  state_d = S_SAVE;
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      S_RET:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      tval_q  <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the registered state only, so reset clears them at once.
  // Redirect targets are word-aligned and taken from the live CSR inputs.
  always_comb begin
    busy             = (state_q != S_IDLE);
    flush            = (state_q == S_FLUSH) || (state_q == S_RET);
    csr_we           = (state_q == S_SAVE);
    csr_mepc_wdata   = '0;
    csr_mcause_wdata = '0;
    csr_mtval_wdata  = '0;
    redirect_valid   = (state_q == S_VECTOR) || (state_q == S_RET);
    redirect_pc      = '0;
    if (state_q == S_SAVE) begin
      csr_mepc_wdata   = pc_q;
      csr_mcause_wdata = {29'd0, cause_q};
      csr_mtval_wdata  = tval_q;
    end
    if (state_q == S_VECTOR) redirect_pc = mtvec & 32'hFFFF_FFFC;
    if (state_q == S_RET)    redirect_pc = mepc_in & 32'hFFFF_FFFC;
  end

  assign trap_count = cnt_q;

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        resetb;
  logic        XB_bubble;
  logic [3:0]  exc_req;
  logic [31:0] exc_pc, exc_tval, mtvec, mepc_in;
  logic        mret_req;

  // DUT A: default counter width; DUT B: CNT_W=2 for saturation.
  logic        a_busy, a_flush, a_we, a_rv;
  logic [31:0] a_mepc, a_mcause, a_mtval, a_rpc;
  logic [7:0]  a_cnt;
  logic        b_busy, b_flush, b_we, b_rv;
  logic [31:0] b_mepc, b_mcause, b_mtval, b_rpc;
  logic [1:0]  b_cnt;

  trap_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .resetb(resetb), .XB_bubble(XB_bubble), .exc_req(exc_req),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_req(mret_req), .mtvec(mtvec),
    .mepc_in(mepc_in), .busy(a_busy), .flush(a_flush), .csr_we(a_we),
    .csr_mepc_wdata(a_mepc), .csr_mcause_wdata(a_mcause), .csr_mtval_wdata(a_mtval),
    .redirect_valid(a_rv), .redirect_pc(a_rpc), .trap_count(a_cnt));

  trap_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .resetb(resetb), .XB_bubble(XB_bubble), .exc_req(exc_req),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_req(mret_req), .mtvec(mtvec),
    .mepc_in(mepc_in), .busy(b_busy), .flush(b_flush), .csr_we(b_we),
    .csr_mepc_wdata(b_mepc), .csr_mcause_wdata(b_mcause), .csr_mtval_wdata(b_mtval),
    .redirect_valid(b_rv), .redirect_pc(b_rpc), .trap_count(b_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] busy, flush, we, rv, rpc, mepc, mcause, mtval, cnt;
  } outs_t;

  typedef struct {
    logic        bub;
    logic [3:0]  exc;
    logic        mret;
    logic [31:0] pc, tval, mtvec, mepc;
    outs_t       exp;
  } row_t;

  // Reference model: a schedule of what each upcoming busy cycle must show.
  // rsel: 0 no target, 1 target from mtvec, 2 target from mepc_in.
  typedef struct {
    logic        fl, we, rv;
    logic [1:0]  rsel;
    logic [31:0] pc, cause, tval;
  } ent_t;

  ent_t        sched[$];
  int unsigned traps;
  int          checks = 0;
  int          failures = 0;
  row_t        tbl[23];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_all(input outs_t e, input string tag);
    chk({tag, ".busy"},   32'(a_busy),  e.busy);
    chk({tag, ".flush"},  32'(a_flush), e.flush);
    chk({tag, ".csr_we"}, 32'(a_we),    e.we);
    chk({tag, ".rv"},     32'(a_rv),    e.rv);
    chk({tag, ".rpc"},    a_rpc,        e.rpc);
    chk({tag, ".mepc"},   a_mepc,       e.mepc);
    chk({tag, ".mcause"}, a_mcause,     e.mcause);
    chk({tag, ".mtval"},  a_mtval,      e.mtval);
    chk({tag, ".cnt"},    32'(a_cnt),   (e.cnt > 255) ? 32'd255 : e.cnt);
    chk({tag, ".b_busy"}, 32'(b_busy),  e.busy);
    chk({tag, ".b_flush"},32'(b_flush), e.flush);
    chk({tag, ".b_we"},   32'(b_we),    e.we);
    chk({tag, ".b_rv"},   32'(b_rv),    e.rv);
    chk({tag, ".b_rpc"},  b_rpc,        e.rpc);
    chk({tag, ".b_mepc"}, b_mepc,       e.mepc);
    chk({tag, ".b_mcause"}, b_mcause,   e.mcause);
    chk({tag, ".b_mtval"},  b_mtval,    e.mtval);
    chk({tag, ".b_cnt"},  32'(b_cnt),   (e.cnt > 3) ? 32'd3 : e.cnt);
  endtask

  function automatic outs_t model_out();
    outs_t o;
    o = '{default: 32'd0};
    o.cnt = traps;
    if (sched.size() != 0) begin
      o.busy  = 1;
      o.flush = 32'(sched[0].fl);
      o.we    = 32'(sched[0].we);
      o.rv    = 32'(sched[0].rv);
      if (sched[0].rsel == 2'd1) o.rpc = (mtvec / 4) * 4;
      if (sched[0].rsel == 2'd2) o.rpc = (mepc_in / 4) * 4;
      if (sched[0].we) begin
        o.mepc   = sched[0].pc;
        o.mcause = sched[0].cause;
        o.mtval  = sched[0].tval;
      end
    end
    return o;
  endfunction

  function automatic void model_reset();
    sched.delete();
    traps = 0;
  endfunction

  // Evaluated just before a rising edge with the inputs that edge will see.
  function automatic void model_edge();
    ent_t e;
    logic [31:0] cause;
    if (!resetb) return;
    if (sched.size() != 0) begin
      e = sched.pop_front();
    end else if (!XB_bubble && exc_req != 0) begin
      cause = 0;
      for (int i = 3; i >= 0; i--) if (exc_req[i]) cause = 32'(2 * i);
      sched.push_back('{fl: 1'b1, we: 1'b0, rv: 1'b0, rsel: 2'd0, pc: 0, cause: 0, tval: 0});
      sched.push_back('{fl: 1'b0, we: 1'b1, rv: 1'b0, rsel: 2'd0, pc: exc_pc, cause: cause, tval: exc_tval});
      sched.push_back('{fl: 1'b0, we: 1'b0, rv: 1'b1, rsel: 2'd1, pc: 0, cause: 0, tval: 0});
      traps++;
    end else if (!XB_bubble && mret_req) begin
      sched.push_back('{fl: 1'b1, we: 1'b0, rv: 1'b1, rsel: 2'd2, pc: 0, cause: 0, tval: 0});
    end
  endfunction

  // One clock: model advances, outputs checked after the edge, returns at negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #3;
    check_all(model_out(), "model");
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    XB_bubble = 0; exc_req = 0; mret_req = 0;
    exc_pc = 0; exc_tval = 0; mtvec = 0; mepc_in = 0;
  endtask

  function automatic row_t mk(input logic [31:0] bub, exc, mret, pc, tval, tv, mp,
                              ebusy, efl, ewe, erv, erpc, ewpc, ewc, ewt, ecnt);
    row_t r;
    r.bub = bub[0]; r.exc = exc[3:0]; r.mret = mret[0];
    r.pc = pc; r.tval = tval; r.mtvec = tv; r.mepc = mp;
    r.exp = '{busy: ebusy, flush: efl, we: ewe, rv: erv, rpc: erpc,
              mepc: ewpc, mcause: ewc, mtval: ewt, cnt: ecnt};
    return r;
  endfunction

  initial begin
    outs_t zero;
    zero = '{default: 32'd0};
    idle_inputs();
    resetb = 0;
    model_reset();
    #1;
    check_all(zero, "reset");
    @(negedge clk);
    @(negedge clk);
    resetb = 1;

    //          bub exc  mr pc      tval     mtvec     mepc     busy fl we rv rpc      wpc     wc wt       cnt
    tbl[0]  = mk(0, 'h2, 0, 'h100, 'hFFFF, 'h203,  0,       1, 1, 0, 0, 0,       0,      0, 0,      1);
    tbl[1]  = mk(0, 0,   0, 0,      0,      'h203,  0,       1, 0, 1, 0, 0,       'h100,  2, 'hFFFF, 1);
    tbl[2]  = mk(0, 0,   0, 0,      0,      'h203,  0,       1, 0, 0, 1, 'h200,   0,      0, 0,      1);
    tbl[3]  = mk(0, 0,   0, 0,      0,      'h203,  0,       0, 0, 0, 0, 0,       0,      0, 0,      1);
    tbl[4]  = mk(0, 0,   1, 0,      0,      0,      'h106,   1, 1, 0, 1, 'h104,   0,      0, 0,      1);
    tbl[5]  = mk(0, 0,   0, 0,      0,      0,      'h106,   0, 0, 0, 0, 0,       0,      0, 0,      1);
    tbl[6]  = mk(0, 'hD, 0, 'h40,  'h11,   'h1000, 0,       1, 1, 0, 0, 0,       0,      0, 0,      2);
    tbl[7]  = mk(0, 0,   0, 0,      0,      'h1000, 0,       1, 0, 1, 0, 0,       'h40,   0, 'h11,   2);
    tbl[8]  = mk(0, 0,   0, 0,      0,      'h1000, 0,       1, 0, 0, 1, 'h1000,  0,      0, 0,      2);
    tbl[9]  = mk(0, 'hC, 0, 'h80,  'h22,   'h1000, 0,       0, 0, 0, 0, 0,       0,      0, 0,      2);
    tbl[10] = mk(0, 'hC, 0, 'h80,  'h22,   'h1000, 0,       1, 1, 0, 0, 0,       0,      0, 0,      3);
    tbl[11] = mk(0, 0,   0, 0,      0,      'h1000, 0,       1, 0, 1, 0, 0,       'h80,   4, 'h22,   3);
    tbl[12] = mk(0, 0,   0, 0,      0,      'h1000, 0,       1, 0, 0, 1, 'h1000,  0,      0, 0,      3);
    tbl[13] = mk(0, 0,   0, 0,      0,      'h1000, 0,       0, 0, 0, 0, 0,       0,      0, 0,      3);
    tbl[14] = mk(1, 'h1, 0, 'h55,  'h66,   'h1000, 0,       0, 0, 0, 0, 0,       0,      0, 0,      3);
    tbl[15] = mk(0, 'h1, 1, 'h300, 'h7,    'h2001, 'h500,   1, 1, 0, 0, 0,       0,      0, 0,      4);
    tbl[16] = mk(0, 0,   0, 0,      0,      'h2001, 'h500,   1, 0, 1, 0, 0,       'h300,  0, 'h7,    4);
    tbl[17] = mk(0, 'h2, 1, 'h999, 'h1,    'h2001, 'h500,   1, 0, 0, 1, 'h2000,  0,      0, 0,      4);
    tbl[18] = mk(0, 0,   0, 0,      0,      'h2001, 'h500,   0, 0, 0, 0, 0,       0,      0, 0,      4);
    tbl[19] = mk(0, 0,   1, 0,      0,      0,      'h20,    1, 1, 0, 1, 'h20,    0,      0, 0,      4);
    tbl[20] = mk(0, 0,   1, 0,      0,      0,      'h24,    0, 0, 0, 0, 0,       0,      0, 0,      4);
    tbl[21] = mk(0, 0,   1, 0,      0,      0,      'h2B,    1, 1, 0, 1, 'h28,    0,      0, 0,      4);
    tbl[22] = mk(0, 0,   0, 0,      0,      0,      0,       0, 0, 0, 0, 0,       0,      0, 0,      4);

    for (int i = 0; i < 23; i++) begin
      XB_bubble = tbl[i].bub; exc_req = tbl[i].exc; mret_req = tbl[i].mret;
      exc_pc = tbl[i].pc; exc_tval = tbl[i].tval; mtvec = tbl[i].mtvec; mepc_in = tbl[i].mepc;
      step();
      check_all(tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Randomized traffic, with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      XB_bubble = ($urandom_range(0, 3) == 0);
      exc_req   = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'd0;
      mret_req  = ($urandom_range(0, 4) == 0);
      exc_pc    = $urandom;
      exc_tval  = $urandom;
      mtvec     = $urandom;
      mepc_in   = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #1 resetb = 0;
        model_reset();
        #1;
        check_all(zero, "rnd_reset");
        resetb = 1;
      end
      step();
    end

    // Reset asserted during SAVE aborts with no redirect afterwards.
    idle_inputs();
    step();
    step();
    step();
    step();
    exc_req = 4'b0100; exc_pc = 32'h44; exc_tval = 32'h88; mtvec = 32'h400;
    step();
    exc_req = 0;
    step();
    chk("save.we_before_reset", 32'(a_we), 32'd1);
    #2 resetb = 0;
    model_reset();
    #1;
    check_all(zero, "save_reset");
    step();
    check_all(zero, "save_reset_next");
    step();
    check_all(zero, "save_reset_next2");

    // Request accepted on the first edge after reset release.
    resetb = 1;
    exc_req = 4'b1000; exc_pc = 32'hABC; exc_tval = 32'h1;
    step();
    chk("post_reset.flush", 32'(a_flush), 32'd1);
    chk("post_reset.cnt", 32'(a_cnt), 32'd1);
    exc_req = 0;
    step();
    chk("post_reset.mcause", a_mcause, 32'd6);
    step();
    step();

    // Five exceptions: the 2-bit counter sticks at 3.
    #1 resetb = 0;
    model_reset();
    #1 resetb = 1;
    for (int k = 0; k < 5; k++) begin
      exc_req = 4'b0010; exc_pc = 32'(k * 4);
      step();
      exc_req = 0;
      step();
      step();
      step();
    end
    chk("sat.cnt8", 32'(a_cnt), 32'd5);
    chk("sat.cnt2", 32'(b_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
